// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared ALU: grant, execute one cycle,
// then hold a tagged response until the consumer takes it.
module alu_arbiter #(
  parameter int W         = 8,
  parameter int PRIO_INIT = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [W-1:0]     req_a0,
  input  logic [W-1:0]     req_b0,
  input  logic [3:0]       req_sel0,
  input  logic [W-1:0]     req_a1,
  input  logic [W-1:0]     req_b1,
  input  logic [3:0]       req_sel1,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [3:0]       alu_sel,
  input  logic [W-1:0]     alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [W-1:0]     rsp_result,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   sel;
  } req_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_nxt;
  logic           prio;
  logic           gnt_id;
  logic           div0;
  req_t [1:0]     req;

  assign req[0] = '{a: req_a0, b: req_b0, sel: req_sel0};
  assign req[1] = '{a: req_a1, b: req_b1, sel: req_sel1};

  // Contention goes to the priority holder; otherwise whoever is asking.
  assign gnt_id = (&req_valid) ? prio : req_valid[1];
  assign div0   = (alu_sel == 4'd3) && (alu_b == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && |req_valid) req_ready[gnt_id] = 1'b1;
    busy      = (state != IDLE);
    rsp_valid = (state == RESP);
  end

  // ALU operand regs are only rewritten on a grant, so they hold between ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
      ops_done   <= '0;
      prio       <= 1'(PRIO_INIT);
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          alu_a   <= req[gnt_id].a;
          alu_b   <= req[gnt_id].b;
          alu_sel <= req[gnt_id].sel;
          rsp_id  <= gnt_id;
        end
        EXEC: begin
          rsp_result <= div0 ? '0 : alu_out;
          rsp_carry  <= (alu_sel == 4'd0) ? alu_carry : 1'b0;
          rsp_err    <= div0 || (alu_sel > 4'd9);
        end
        RESP: if (rsp_ready) begin
          ops_done <= ops_done + 1'b1;
          prio     <= ~rsp_id;
        end
        default: ;
      endcase
    end
  end

endmodule
